scr1_dmem_copy_dma: RTL and testbench

Word-copy DMA engine that acts as the initiator on the SCR1 core data-memory interface (dmem_req/cmd/width/addr/wdata, dmem_req_ack/rdata/resp). It connects to the data port of a TCM or to any dmem-interface responder.
On a start pulse it reads LEN words from a source address and writes each word to a destination address, one transaction outstanding at a time. It reports busy, a done pulse and a sticky error flag to its controller.

---
 rtl/scr1_dmem_copy_dma.sv | 179 +++++++++++++++++
 tb/tb_scr1_dmem_copy_dma.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_dmem_copy_dma.sv
// Word-copy DMA initiator on the SCR1 dmem interface: reads LEN words from src
// and writes them to dst, one transaction in flight, with busy/done/err status.

package scr1_memif_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_copy_dma
    import scr1_memif_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [LEN_W-1:0]     words_done,
    output logic                 dmem_req,
    output type_scr1_mem_cmd_e   dmem_cmd,
    output type_scr1_mem_width_e dmem_width,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_req_ack,
    input  logic [31:0]          dmem_rdata,
    input  type_scr1_mem_resp_e  dmem_resp
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ, ST_WR_WAIT, ST_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [31:0]        buf_q, buf_d;
    logic               err_q, err_d;
    logic [LEN_W-1:0]   wd_q, wd_d;
    logic [LEN_W-1:0]   wd_inc;
    logic               req_q, req_d;
    type_scr1_mem_cmd_e cmd_q, cmd_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = ^{src_addr[1:0], dst_addr[1:0]};
    assign wd_inc          = wd_q + LEN_W'(1);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        buf_d   = buf_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    wd_d  = '0;
                    if (len != '0) begin
                        src_d   = {src_addr[31:2], 2'b00};
                        dst_d   = {dst_addr[31:2], 2'b00};
                        len_d   = len;
                        state_d = ST_RD_REQ;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RD_REQ: if (dmem_req_ack) state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
                    buf_d   = dmem_rdata;
                    state_d = ST_WR_REQ;
                end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_WR_REQ: if (dmem_req_ack) state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
                    wd_d    = wd_inc;
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    state_d = (wd_inc == len_q) ? ST_FIN : ST_RD_REQ;
                end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are registered from the next state, so a pending request
        // holds cmd/addr/wdata until acked (state_d and src/dst don't move).
        req_d   = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_d == ST_RD_REQ) begin
            cmd_d  = SCR1_MEM_CMD_RD;
            addr_d = src_d;
        end else if (state_d == ST_WR_REQ) begin
            cmd_d   = SCR1_MEM_CMD_WR;
            addr_d  = dst_d;
            wdata_d = buf_d;
        end
        done_d = (state_d == ST_FIN);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            req_q   <= 1'b0;
            cmd_q   <= SCR1_MEM_CMD_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            req_q   <= req_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_done = wd_q;
    assign dmem_req   = req_q;
    assign dmem_cmd   = cmd_q;
    assign dmem_width = SCR1_MEM_WIDTH_WORD;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_scr1_dmem_copy_dma.sv
// Bench for scr1_dmem_copy_dma: memory responder with programmable ack/resp
// delays and read-error injection, table vectors, random runs and corner sequences.

module tb_scr1_dmem_copy_dma;
    import scr1_memif_pkg::*;

    localparam int LEN_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [31:0]          src_addr, dst_addr;
    logic [LEN_W-1:0]     len;
    logic                 busy, done, err;
    logic [LEN_W-1:0]     words_done;
    logic                 dmem_req;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [31:0]          dmem_addr, dmem_wdata;
    logic                 dmem_req_ack;
    logic [31:0]          dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;

    scr1_dmem_copy_dma #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
        .words_done(words_done), .dmem_req(dmem_req), .dmem_cmd(dmem_cmd),
        .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    always #5 clk = ~clk;

    // ---------------- responder ----------------
    typedef struct packed { logic wr; logic [31:0] a; } tr_t;

    logic [31:0] mem [logic [31:0]];
    tr_t         trace_q [$];
    int          cfg_ack = 0, cfg_rsp = 0;
    bit          cfg_er_en = 0;
    logic [31:0] cfg_er_addr = '0;
    int          ack_cnt, rsp_cnt;
    logic        pending, pend_er, pend_wr, hold_v;
    logic [31:0] pend_addr, pend_wdata, rd_data;
    logic [64:0] hold_bus;
    int          stab_bad = 0, req_cycles = 0;

    assign dmem_req_ack = dmem_req && (ack_cnt == cfg_ack);
    assign dmem_resp    = (pending && rsp_cnt == 0) ?
                          (pend_er ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK) :
                          SCR1_MEM_RESP_NOTRDY;
    assign dmem_rdata   = rd_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0; ack_cnt <= 0; rsp_cnt <= 0; hold_v <= 1'b0;
            pend_er <= 1'b0; pend_wr <= 1'b0; rd_data <= '0;
        end else begin
            if (pending) begin
                if (rsp_cnt == 0) begin
                    pending <= 1'b0;
                    if (pend_wr && !pend_er) mem[pend_addr] = pend_wdata;
                end else rsp_cnt <= rsp_cnt - 1;
            end
            if (dmem_req) begin
                req_cycles++;
                if (hold_v && ({dmem_cmd, dmem_addr, dmem_wdata} !== hold_bus)) stab_bad++;
                if (dmem_addr[1:0] != 2'b00 || dmem_width != SCR1_MEM_WIDTH_WORD) stab_bad++;
                if (dmem_req_ack) begin
                    hold_v     <= 1'b0;
                    ack_cnt    <= 0;
                    pending    <= 1'b1;
                    rsp_cnt    <= cfg_rsp;
                    pend_wr    <= (dmem_cmd == SCR1_MEM_CMD_WR);
                    pend_addr  <= dmem_addr;
                    pend_wdata <= dmem_wdata;
                    pend_er    <= (dmem_cmd == SCR1_MEM_CMD_RD) && cfg_er_en && (dmem_addr == cfg_er_addr);
                    rd_data    <= mem.exists(dmem_addr) ? mem[dmem_addr] : 32'hDEAD_BEEF;
                    trace_q.push_back({dmem_cmd == SCR1_MEM_CMD_WR, dmem_addr});
                end else begin
                    hold_v   <= 1'b1;
                    hold_bus <= {dmem_cmd, dmem_addr, dmem_wdata};
                    ack_cnt  <= ack_cnt + 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: copy proceeds word by word until the erroring read (if any);
    // each full word costs (ack_wait+1)+(resp_wait+1) cycles on read and on write.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input int n,
                       input int a, input int r, input int ei, input bit mid,
                       input string tag, output int cyc);
        logic [31:0] sa, da;
        logic [31:0] orig [$];
        tr_t         exp_tr [$];
        int          nw, exp_cyc, ph;
        bit          er, bz, seen;
        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
        er = (ei >= 0) && (ei < n);
        nw = er ? ei : n;
        ph = (a + 1) + (r + 1);
        exp_cyc = (n == 0) ? 1 : (er ? nw * 2 * ph + ph + 1 : n * 2 * ph + 1);
        for (int i = 0; i < nw; i++) begin
            exp_tr.push_back({1'b0, sa + 32'(4 * i)});
            exp_tr.push_back({1'b1, da + 32'(4 * i)});
        end
        if (er) exp_tr.push_back({1'b0, sa + 32'(4 * nw)});

        mem.delete();
        trace_q.delete();
        for (int i = 0; i < n; i++) begin
            orig.push_back($urandom);
            mem[sa + 32'(4 * i)] = orig[i];
        end
        cfg_ack = a; cfg_rsp = r;
        cfg_er_en = er; cfg_er_addr = sa + 32'(4 * (er ? ei : 0));
        stab_bad = 0; req_cycles = 0;

        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; bz = 1'b1; seen = 1'b0;
        while (cyc < 4000) begin
            if (done) begin seen = 1'b1; break; end
            if (!busy) bz = 1'b0;
            if (mid && cyc == 3) begin
                start = 1'b1; src_addr = 32'h5000; dst_addr = 32'h6000; len = 7;
            end else start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, 64'(seen), 1);
        chk({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, " busy_held"}, 64'(bz & busy), 1);
        chk({tag, " words_done"}, 64'(words_done), 64'(nw));
        chk({tag, " err"}, 64'(err), 64'(er));
        chk({tag, " n_trans"}, 64'(trace_q.size()), 64'(exp_tr.size()));
        for (int i = 0; i < exp_tr.size() && i < trace_q.size(); i++)
            chk({tag, " trans"}, 64'(trace_q[i]), 64'(exp_tr[i]));
        for (int i = 0; i < nw; i++) begin
            logic [31:0] da_i;
            da_i = da + 32'(4 * i);
            chk({tag, " mem"}, mem.exists(da_i) ? 64'(mem[da_i]) : 64'hBAD, 64'(orig[i]));
        end
        chk({tag, " mem_entries"}, 64'(mem.num()), 64'(n + nw));
        chk({tag, " req_stable"}, 64'(stab_bad), 0);
        if (n == 0) chk({tag, " no_req"}, 64'(req_cycles), 0);
        @(negedge clk);
        chk({tag, " done_pulse"}, 64'({done, busy}), 0);
    endtask

    typedef struct {
        logic [31:0] src, dst;
        int          len, ack, rsp, err_idx;
        bit          mid;
        int          exp_wd;
        bit          exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [7];
    int   cyc;

    initial begin
        vecs[0] = '{32'h100, 32'h200, 4, 0, 0, -1, 1'b0, 4, 1'b0, 17};
        vecs[1] = '{32'h100, 32'h200, 4, 3, 2, -1, 1'b0, 4, 1'b0, 57};
        vecs[2] = '{32'h100, 32'h200, 4, 0, 0,  2, 1'b0, 2, 1'b1, 11};
        vecs[3] = '{32'h100, 32'h300, 1, 0, 0, -1, 1'b0, 1, 1'b0, 5};
        vecs[4] = '{32'h103, 32'h201, 2, 0, 0, -1, 1'b0, 2, 1'b0, 9};
        vecs[5] = '{32'hFFFF_FFFC, 32'h200, 2, 0, 0, -1, 1'b1, 2, 1'b0, 9};
        vecs[6] = '{32'h0, 32'h0, 0, 0, 0, -1, 1'b0, 0, 1'b0, 1};

        rst_n = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        #3 rst_n = 1'b0;
        #2;
        chk("reset_outs", {busy, done, err, words_done, dmem_req, 1'(dmem_cmd)}, 0);
        chk("reset_bus", {dmem_addr, dmem_wdata}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].ack, vecs[i].rsp,
                vecs[i].err_idx, vecs[i].mid, tag, cyc);
            chk({tag, " tbl_cycle"}, 64'(cyc), 64'(vecs[i].exp_cyc));
            chk({tag, " tbl_wd"}, 64'(words_done), 64'(vecs[i].exp_wd));
            chk({tag, " tbl_err"}, 64'(err), 64'(vecs[i].exp_err));
        end

        for (int i = 0; i < 10; i++) begin
            int n, ei;
            n  = int'($urandom_range(1, 6));
            ei = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run(32'h1000 + 32'($urandom_range(0, 255)), 32'h8000 + 32'($urandom_range(0, 255)),
                n, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), ei, 1'b0,
                $sformatf("rnd%0d", i), cyc);
        end

        // Reset while the DUT waits on a write response.
        mem.delete(); trace_q.delete();
        cfg_ack = 0; cfg_rsp = 3; cfg_er_en = 0;
        mem[32'h100] = 32'h1111_2222;
        @(negedge clk);
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h200; len = 4;
        @(negedge clk);
        start = 1'b0;
        begin
            int k;
            k = 0;
            while (!(pending && pend_wr) && k < 100) begin @(negedge clk); k++; end
            chk("rst_mid reached_wr_wait", 64'(pending && pend_wr), 1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid outs", {busy, done, err, words_done, dmem_req, 1'(dmem_cmd)}, 0);
        chk("rst_mid bus", {dmem_addr, dmem_wdata}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(32'h100, 32'h200, 3, 1, 1, -1, 1'b0, "post_rst", cyc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
